mpu_i2c_master: RTL and testbench
=================================

Name: mpu_i2c_master

Overview:
- Byte-level I2C master that consumes the command word from the MPU command-mid stage: en_start, rd_now, n, m, data_packed.
- Executes either a register write (init, e.g. 0x6B<-0x00) or a register-addressed burst read (e.g. 14 bytes from 0x3B) on the MPU-6050 bus.
- Streams read bytes out with a valid strobe for the downstream sensor-frame assembler.
- Drives open-drain SCL/SDA through the pad-level output enables.

Parameters:
CLK_FREQ, 50_000_000, system clock in Hz
I2C_FREQ, 400_000, SCL frequency in Hz
DEV_ADDR, 7'h68, 7-bit slave address

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en_start  in  1  one-cycle command strobe
rd_now  in  1  1 = burst read, 0 = write-only
n  in  16  write bytes minus 1 (0 = 1 byte, >=1 = 2 bytes)
m  in  16  read bytes minus 1 (read mode only)
data_packed  in  16  [7:0] = first write byte (reg addr), [15:8] = second byte
sda_i  in  1  sampled SDA line
scl_oe  out  1  1 = pull SCL low
sda_oe  out  1  1 = pull SDA low
rd_data  out  8  received byte
rd_valid  out  1  one-cycle strobe, rd_data valid
rd_idx  out  16  index of the current rd_data (0-based)
busy  out  1  transaction in progress
done  out  1  one-cycle end-of-transaction pulse
ack_err  out  1  last transaction saw a NACK; held until next accepted command

Behaviour:
- Reset is asynchronous, active-low; clock is clk. All outputs reset to 0, so the bus is released and both lines float high. Reset mid-transaction releases the bus immediately; no STOP is generated.
- Quarter-bit tick: DIV = CLK_FREQ/(4*I2C_FREQ), integer floor; default 31, giving 124 clk per bit. Each bit is quarters q0..q3.
  - q0: SCL low, update SDA.
  - q1: SCL low.
  - q2: SCL released; sample sda_i at end of q2.
  - q3: SCL released.
- Command acceptance: en_start is accepted only when busy=0. On accept, latch rd_now, n, m, data_packed and clear ack_err. busy=1 on the next cycle. en_start while busy is ignored.
- Write count: wcnt = 1 if n==0, else 2. Values of n > 1 are clamped to 2 bytes.
- FSM states: IDLE, START, WR_BIT, WR_ACK, RSTART, RD_BIT, RD_ACK, STOP, FINISH.
- Write frame (rd_now=0): START, addr+W (0xD0 for default), ACK, byte0, ACK, [byte1, ACK], STOP.
- Read frame (rd_now=1): START, 0xD0, ACK, byte0, ACK, RSTART, addr+R (0xD1), ACK, then m+1 data bytes, STOP. byte1 is never sent in read mode.
  - Master ACKs every data byte except the last, which gets a NACK.
- START: SDA falls while SCL is high, held for 2 quarters, then SCL low.
- RSTART: SDA released with SCL low, SCL released, then SDA falls.
- STOP: SDA low, SCL released, then SDA released.
- Bit order is MSB first.
- rd_valid pulses for 1 clk in the cycle after the 8th bit of each read byte is sampled. rd_idx increments after each pulse, 0..m.
- Slave ACK check: sda_i==1 in any slave-ACK slot sets ack_err=1 and skips to STOP. The remaining bytes are abandoned.
- FINISH lasts 1 cycle: done=1 and busy=0 on the same edge. ack_err remains valid after done.
- No clock stretching; SCL is not monitored. No arbitration.

Decomposition:
- Package mpu_i2c_pkg holds:
  - FSM state enum.
  - DEV_ADDR default 7'h68.
  - MPU register constants: PWR_MGMT_1=8'h6B, ACCEL_XOUT_H=8'h3B.
  - Burst length constant 14.
- Sub-module i2c_quarter_tick: free-running divider producing a 1-clk tick every DIV cycles. It is enabled while busy and reset to 0 on accept.

Test Plan:
- Init write: en_start, rd_now=0, n=1, data_packed=16'h006B, slave ACKs everything -> bus decodes S D0 A 6B A 00 A P; done once; ack_err=0; no rd_valid.
- Burst read: rd_now=1, n=0, m=13, data_packed=16'h003B; slave returns 0x00..0x0D -> S D0 A 3B A Sr D1 A, then 14 bytes. rd_valid fires 14 times with rd_data=rd_idx=0..13. Master ACKs bytes 0..12, NACKs byte 13, then P.
- Address NACK: slave silent (sda_i=1) -> ack_err=1, STOP right after the address byte, done pulse, no rd_valid.
- Busy ignore: second en_start 200 clk into a write -> frame unchanged. en_start after done starts a new frame.
- Reset mid-read: rst_n low during read byte 5 -> scl_oe=sda_oe=busy=rd_valid=0 asynchronously. After release, a fresh read completes correctly.
- Clamp: rd_now=0, n=5, data_packed=16'hA55A -> exactly two data bytes 5A, A5, then P.

Source files
------------

// File: rtl/mpu_i2c_pkg.sv
// rtl/mpu_i2c_pkg.sv - shared types and MPU-6050 constants for the I2C master
package mpu_i2c_pkg;

   typedef enum logic [3:0] {
      IDLE, START, WR_BIT, WR_ACK, RSTART, RD_BIT, RD_ACK, STOP, FINISH
   } state_e;

   // Which byte the write shifter currently carries
   typedef enum logic [1:0] {
      SEL_ADDR_W, SEL_BYTE0, SEL_BYTE1, SEL_ADDR_R
   } wsel_e;

   localparam logic [6:0]  DEV_ADDR_DEFAULT = 7'h68;
   localparam logic [7:0]  PWR_MGMT_1       = 8'h6B;
   localparam logic [7:0]  ACCEL_XOUT_H     = 8'h3B;
   localparam int unsigned BURST_LEN        = 14;

endpackage

// File: rtl/i2c_quarter_tick.sv
// rtl/i2c_quarter_tick.sv - free-running divider giving one tick per quarter bit
module i2c_quarter_tick #(
   parameter int unsigned DIV = 31
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/mpu_i2c_master.sv
// rtl/mpu_i2c_master.sv - byte-level I2C master for MPU-6050 register write / burst read
module mpu_i2c_master
   import mpu_i2c_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned I2C_FREQ = 400_000,
   parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en_start,
   input  logic        rd_now,
   input  logic [15:0] n,
   input  logic [15:0] m,
   input  logic [15:0] data_packed,
   input  logic        sda_i,
   output logic        scl_oe,
   output logic        sda_oe,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic [15:0] rd_idx,
   output logic        busy,
   output logic        done,
   output logic        ack_err
);

   localparam int unsigned DIV = CLK_FREQ / (4 * I2C_FREQ);

   state_e      state_q, state_d;
   wsel_e       sel_q, sel_d;
   logic [1:0]  qtr_q, qtr_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [7:0]  rd_data_q, rd_data_d;
   logic [15:0] rd_idx_q, rd_idx_d;
   logic        ack_err_q, ack_err_d, busy_q, busy_d, done_q, done_d;
   logic        rd_valid_q, rd_valid_d, scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
   logic        rd_now_q, two_q;
   logic [15:0] m_q, data_q;
   logic        tick, accept, sample, slot_end, last_rd;

   i2c_quarter_tick #(.DIV(DIV)) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (accept),
      .en_i   (busy_q),
      .tick_o (tick)
   );

   assign accept   = en_start && !busy_q;
   assign sample   = tick && (qtr_q == 2'd2);
   assign slot_end = tick && (qtr_q == 2'd3);
   // rd_idx has already advanced past the byte being acknowledged
   assign last_rd  = (rd_idx_q - 16'd1) == m_q;

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      qtr_d      = tick ? qtr_q + 2'd1 : qtr_q;
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      ack_err_d  = ack_err_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      rd_idx_d   = rd_valid_q ? rd_idx_q + 16'd1 : rd_idx_q;
      scl_oe_d   = 1'b0;
      sda_oe_d   = 1'b0;
      case (state_q)
         IDLE: if (accept) begin
            busy_d    = 1'b1;
            ack_err_d = 1'b0;
            rd_idx_d  = '0;
            qtr_d     = '0;
            state_d   = START;
         end
         START: begin
            scl_oe_d = (qtr_q == 2'd3);
            sda_oe_d = (qtr_q != 2'd0);
            if (slot_end) begin
               shreg_d = {DEV_ADDR, 1'b0};
               sel_d   = SEL_ADDR_W;
               bit_d   = '0;
               state_d = WR_BIT;
            end
         end
         WR_BIT: begin
            scl_oe_d = ~qtr_q[1];
            sda_oe_d = ~shreg_q[7];
            if (slot_end) begin
               shreg_d = {shreg_q[6:0], 1'b0};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = WR_ACK;
            end
         end
         WR_ACK: begin
            scl_oe_d = ~qtr_q[1];
            if (sample && sda_i) ack_err_d = 1'b1;
            if (slot_end) begin
               if (ack_err_q) begin
                  state_d = STOP;
               end else begin
                  case (sel_q)
                     SEL_ADDR_W: begin
                        shreg_d = data_q[7:0];
                        sel_d   = SEL_BYTE0;
                        state_d = WR_BIT;
                     end
                     SEL_BYTE0: begin
                        if (rd_now_q) begin
                           state_d = RSTART;
                        end else if (two_q) begin
                           shreg_d = data_q[15:8];
                           sel_d   = SEL_BYTE1;
                           state_d = WR_BIT;
                        end else begin
                           state_d = STOP;
                        end
                     end
                     SEL_BYTE1: state_d = STOP;
                     default:   state_d = RD_BIT;
                  endcase
               end
            end
         end
         RSTART: begin
            scl_oe_d = (qtr_q == 2'd0) || (qtr_q == 2'd3);
            sda_oe_d = qtr_q[1];
            if (slot_end) begin
               shreg_d = {DEV_ADDR, 1'b1};
               sel_d   = SEL_ADDR_R;
               state_d = WR_BIT;
            end
         end
         RD_BIT: begin
            scl_oe_d = ~qtr_q[1];
            if (sample) begin
               shreg_d = {shreg_q[6:0], sda_i};
               if (bit_q == 3'd7) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = {shreg_q[6:0], sda_i};
               end
            end
            if (slot_end) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RD_ACK;
            end
         end
         RD_ACK: begin
            scl_oe_d = ~qtr_q[1];
            sda_oe_d = ~last_rd;
            if (slot_end) state_d = last_rd ? STOP : RD_BIT;
         end
         STOP: begin
            scl_oe_d = ~qtr_q[1];
            sda_oe_d = (qtr_q == 2'd1) || (qtr_q == 2'd2);
            if (slot_end) state_d = FINISH;
         end
         FINISH: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sel_q      <= SEL_ADDR_W;
         qtr_q      <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
         ack_err_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_idx_q   <= '0;
         scl_oe_q   <= 1'b0;
         sda_oe_q   <= 1'b0;
         rd_now_q   <= 1'b0;
         two_q      <= 1'b0;
         m_q        <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         qtr_q      <= qtr_d;
         bit_q      <= bit_d;
         shreg_q    <= shreg_d;
         ack_err_q  <= ack_err_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_idx_q   <= rd_idx_d;
         scl_oe_q   <= scl_oe_d;
         sda_oe_q   <= sda_oe_d;
         if (accept) begin
            rd_now_q <= rd_now;
            two_q    <= (n != 16'd0);
            m_q      <= m;
            data_q   <= data_packed;
         end
      end
   end

   assign scl_oe   = scl_oe_q;
   assign sda_oe   = sda_oe_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign rd_idx   = rd_idx_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign ack_err  = ack_err_q;

endmodule

// File: tb/tb_mpu_i2c_master.sv
// tb/tb_mpu_i2c_master.sv - scoreboard bench: bus decoder, MPU slave model, read-stream checks
module tb_mpu_i2c_master;

   localparam int unsigned CLK_FREQ = 50_000_000;
   localparam int unsigned I2C_FREQ = 1_000_000;
   localparam int          QDIV     = CLK_FREQ / (4 * I2C_FREQ);
   localparam int          BIT_CLK  = 4 * QDIV;
   localparam logic [11:0] EV_S     = 12'h400;
   localparam logic [11:0] EV_P     = 12'h800;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en_start = 1'b0;
   logic        rd_now = 1'b0;
   logic [15:0] n = '0, m = '0, data_packed = '0;
   logic        sda_i, scl_oe, sda_oe, rd_valid, busy, done, ack_err;
   logic [7:0]  rd_data;
   logic [15:0] rd_idx;
   logic        slv_oe = 1'b0;
   wire         scl_line = ~scl_oe;
   wire         sda_line = ~sda_oe & ~slv_oe;

   assign sda_i = sda_line;
   always #5 clk = ~clk;

   mpu_i2c_master #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ), .DEV_ADDR(7'h68)) dut (
      .clk(clk), .rst_n(rst_n), .en_start(en_start), .rd_now(rd_now), .n(n), .m(m),
      .data_packed(data_packed), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_idx(rd_idx), .busy(busy),
      .done(done), .ack_err(ack_err)
   );

   int total = 0, bad = 0;
   int done_cnt = 0, rdv_cnt = 0, cyc = 0;
   logic [11:0] exp_bus[$];
   logic [23:0] exp_rd[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic bus_event(input logic [11:0] ev);
      if (exp_bus.size() == 0) chk("bus_unexpected", {20'h0, ev}, 32'hFFFF_FFFF);
      else chk("bus_event", {20'h0, ev}, {20'h0, exp_bus.pop_front()});
   endtask

   function automatic void push_byte(input logic [7:0] b, input logic ack);
      exp_bus.push_back({3'b000, ack, b});
   endfunction

   function automatic void push_write(input logic [7:0] b0, input logic [7:0] b1, input logic two);
      exp_bus.push_back(EV_S);
      push_byte(8'hD0, 1'b0);
      push_byte(b0, 1'b0);
      if (two) push_byte(b1, 1'b0);
      exp_bus.push_back(EV_P);
   endfunction

   function automatic void push_read(input logic [7:0] reg_a, input logic [7:0] base, input int cnt);
      logic [7:0] v;
      exp_bus.push_back(EV_S);
      push_byte(8'hD0, 1'b0);
      push_byte(reg_a, 1'b0);
      exp_bus.push_back(EV_S);
      push_byte(8'hD1, 1'b0);
      for (int k = 0; k < cnt; k++) begin
         v = base + 8'(k);
         push_byte(v, (k == cnt - 1));
         exp_rd.push_back({16'(k), v});
      end
      exp_bus.push_back(EV_P);
   endfunction

   always @(posedge clk) cyc++;

   // Wire decoder plus a behavioural MPU slave sharing the same edge detection
   logic       prev_scl = 1'b1, prev_sda = 1'b1;
   int         mon_bits = 0, sl_bits = 0, last_rise = 0;
   logic       per_done = 1'b0, ack_en = 1'b1;
   logic [7:0] mon_byte = '0, sl_byte = '0, tx_base = '0, tx_idx = '0;
   logic       sl_first = 1'b0, sl_tx = 1'b0, sl_ack = 1'b0, sl_rdreq = 1'b0;

   always @(negedge clk) begin
      logic scl, sda;
      logic [7:0] tv;
      scl = scl_line;
      sda = sda_line;
      if (!rst_n) begin
         mon_bits = 0; sl_bits = 0; sl_tx = 1'b0; sl_first = 1'b0; slv_oe = 1'b0;
      end else if (scl && prev_scl && prev_sda && !sda) begin
         bus_event(EV_S);
         mon_bits = 0; sl_bits = 0; sl_first = 1'b1; sl_tx = 1'b0;
      end else if (scl && prev_scl && !prev_sda && sda) begin
         bus_event(EV_P);
         mon_bits = 0; sl_bits = 0; sl_tx = 1'b0;
      end else if (!prev_scl && scl) begin
         if (!per_done && mon_bits >= 1 && mon_bits <= 7) begin
            chk("scl_period", cyc - last_rise, BIT_CLK);
            per_done = 1'b1;
         end
         last_rise = cyc;
         if (mon_bits < 8) mon_byte = {mon_byte[6:0], sda};
         else bus_event({3'b000, sda, mon_byte});
         mon_bits = (mon_bits == 8) ? 0 : mon_bits + 1;
         if (sl_bits < 8) begin
            if (!sl_tx) begin
               sl_byte = {sl_byte[6:0], sda};
               if (sl_bits == 7) begin
                  sl_ack   = ack_en && (!sl_first || sl_byte[7:1] == 7'h68);
                  sl_rdreq = sl_first && sl_byte[0];
               end
            end
            sl_bits++;
         end else begin
            if (sl_tx) begin
               if (sda) sl_tx = 1'b0;
               else tx_idx++;
            end else if (sl_ack && sl_rdreq) begin
               sl_tx  = 1'b1;
               tx_idx = '0;
            end
            sl_first = 1'b0; sl_rdreq = 1'b0; sl_bits = 0;
         end
      end else if (prev_scl && !scl) begin
         tv = tx_base + tx_idx;
         if (sl_bits == 8) slv_oe = !sl_tx && sl_ack;
         else if (sl_tx) slv_oe = ~tv[7 - sl_bits];
         else slv_oe = 1'b0;
      end
      prev_scl = scl;
      prev_sda = sda;
   end

   always @(negedge clk) begin
      if (rst_n && rd_valid) begin
         rdv_cnt++;
         if (exp_rd.size() == 0) chk("rd_unexpected", {8'h0, rd_idx, rd_data}, 32'hFFFF_FFFF);
         else chk("rd_idx_data", {8'h0, rd_idx, rd_data}, {8'h0, exp_rd.pop_front()});
      end
      if (done) begin
         done_cnt++;
         chk("busy_at_done", busy, 1'b0);
      end
   end

   task automatic send(input logic rd, input logic [15:0] nn, input logic [15:0] mm, input logic [15:0] dp);
      @(negedge clk);
      en_start = 1'b1; rd_now = rd; n = nn; m = mm; data_packed = dp;
      @(negedge clk);
      en_start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk(tag, seen, 1'b1);
   endtask

   initial begin
      int d0, r0;
      logic ok;
      repeat (3) @(negedge clk);
      chk("reset_outs", {scl_oe, sda_oe, rd_valid, busy, done, ack_err, rd_data, rd_idx}, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // init write 0x6B <- 0x00
      d0 = done_cnt; r0 = rdv_cnt;
      push_write(8'h6B, 8'h00, 1'b1);
      send(1'b0, 16'd1, 16'd0, 16'h006B);
      chk("busy_after_accept", busy, 1'b1);
      wait_done("init_done", 60 * BIT_CLK);
      repeat (4) @(negedge clk);
      chk("init_ack_err", ack_err, 1'b0);
      chk("init_done_cnt", done_cnt - d0, 1);
      chk("init_no_rd", rdv_cnt - r0, 0);
      chk("init_bus_left", exp_bus.size(), 0);

      // 14-byte burst read from 0x3B
      d0 = done_cnt; r0 = rdv_cnt; tx_base = 8'h00;
      push_read(8'h3B, 8'h00, 14);
      send(1'b1, 16'd0, 16'd13, 16'h003B);
      wait_done("burst_done", 250 * BIT_CLK);
      repeat (4) @(negedge clk);
      chk("burst_rd_cnt", rdv_cnt - r0, 14);
      chk("burst_done_cnt", done_cnt - d0, 1);
      chk("burst_ack_err", ack_err, 1'b0);
      chk("burst_rd_idx_end", rd_idx, 16'd14);
      chk("burst_queues_left", exp_bus.size() + exp_rd.size(), 0);

      // silent slave: NACK on address byte
      d0 = done_cnt; r0 = rdv_cnt; ack_en = 1'b0;
      exp_bus.push_back(EV_S);
      push_byte(8'hD0, 1'b1);
      exp_bus.push_back(EV_P);
      send(1'b1, 16'd0, 16'd13, 16'h003B);
      wait_done("nack_done", 60 * BIT_CLK);
      repeat (4) @(negedge clk);
      chk("nack_ack_err", ack_err, 1'b1);
      chk("nack_done_cnt", done_cnt - d0, 1);
      chk("nack_no_rd", rdv_cnt - r0, 0);
      chk("nack_bus_left", exp_bus.size(), 0);
      ack_en = 1'b1;

      // en_start while busy is ignored, next one after done is taken
      d0 = done_cnt;
      push_write(8'h11, 8'h00, 1'b0);
      send(1'b0, 16'd0, 16'd0, 16'h0011);
      chk("ack_err_cleared", ack_err, 1'b0);
      repeat (200) @(negedge clk);
      send(1'b1, 16'd1, 16'd3, 16'hFFFF);
      wait_done("busy_ign_done", 60 * BIT_CLK);
      push_write(8'h22, 8'h00, 1'b0);
      send(1'b0, 16'd0, 16'd0, 16'h0022);
      wait_done("after_done_frame", 60 * BIT_CLK);
      repeat (4) @(negedge clk);
      chk("busy_ign_done_cnt", done_cnt - d0, 2);
      chk("busy_ign_bus_left", exp_bus.size(), 0);

      // asynchronous reset during read byte 5, then a clean read
      tx_base = 8'h80;
      push_read(8'h3B, 8'h80, 14);
      send(1'b1, 16'd0, 16'd13, 16'h003B);
      ok = 1'b0;
      for (int k = 0; k < 200 * BIT_CLK && !ok; k++) begin
         @(negedge clk);
         if (rd_idx == 16'd5) ok = 1'b1;
      end
      chk("reach_byte5", ok, 1'b1);
      repeat (3 * BIT_CLK) @(negedge clk);
      chk("busy_before_reset", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outs", {scl_oe, sda_oe, busy, rd_valid}, 4'h0);
      exp_bus.delete();
      exp_rd.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      d0 = done_cnt; r0 = rdv_cnt; tx_base = 8'h40;
      push_read(8'h3B, 8'h40, 14);
      send(1'b1, 16'd0, 16'd13, 16'h003B);
      wait_done("post_reset_done", 250 * BIT_CLK);
      repeat (4) @(negedge clk);
      chk("post_reset_rd_cnt", rdv_cnt - r0, 14);
      chk("post_reset_queues_left", exp_bus.size() + exp_rd.size(), 0);

      // n > 1 clamps to two write bytes
      d0 = done_cnt;
      push_write(8'h5A, 8'hA5, 1'b1);
      send(1'b0, 16'd5, 16'd0, 16'hA55A);
      wait_done("clamp_done", 60 * BIT_CLK);
      repeat (4) @(negedge clk);
      chk("clamp_done_cnt", done_cnt - d0, 1);
      chk("clamp_bus_left", exp_bus.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
